// File: rtl/alu_op_scheduler.sv
// Round-robin front end for one shared ALU (ADD/XOR/MUL/AND): grants one requester,
// runs the operation for a fixed latency, then returns an ID-tagged result over valid/ready.
module alu_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [1:0]               rsp_op,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     busy
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDW-1:0]       r_rr_ptr;
  logic [3:0]           r_cnt;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [IDW-1:0]       r_id;
  logic                 r_rsp_valid;
  logic [2*WIDTH-1:0]   r_result;

  logic [1:0]           w_op_arr [NUM_REQ];
  logic [WIDTH-1:0]     w_a_arr  [NUM_REQ];
  logic [WIDTH-1:0]     w_b_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic [IDW:0]         w_shamt;
  logic [2*NUM_REQ-1:0] w_rot_full;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_any;
  logic [IDW-1:0]       w_gnt_id;
  logic [1:0]           w_gnt_op;
  logic [3:0]           w_lat_m1;
  logic                 w_accept;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_alu;

  // Per-requester views of the flattened request buses, plus the one-hot grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_op_arr[gi] = req_op[2*gi +: 2];
    assign w_a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
    assign w_b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
    assign w_gnt_oh[gi] = w_any && (w_gnt_id == IDW'(gi));
  end

  // Rotate the request vector so bit 0 is the requester just after the last winner.
  assign w_shamt    = {1'b0, r_rr_ptr} + (IDW+1)'(1);
  assign w_rot_full = {req_valid, req_valid} >> w_shamt;
  assign w_rot      = w_rot_full[NUM_REQ-1:0];

  always_comb begin
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any    = 1'b1;
        w_gnt_id = IDW'((int'(r_rr_ptr) + 1 + k) % NUM_REQ);
      end
    end
  end

  assign w_gnt_op  = w_op_arr[w_gnt_id];
  assign w_lat_m1  = (w_gnt_op == OP_MUL) ? 4'(MUL_LAT - 1) : 4'd0;
  assign w_accept  = (r_state == IDLE) && !rst && w_any;
  assign req_ready = ((r_state == IDLE) && !rst) ? w_gnt_oh : '0;

  assign w_a_ext = {{WIDTH{1'b0}}, r_a};
  assign w_b_ext = {{WIDTH{1'b0}}, r_b};

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = w_a_ext + w_b_ext;
      OP_XOR:  w_alu = w_a_ext ^ w_b_ext;
      OP_MUL:  w_alu = w_a_ext * w_b_ext;
      OP_AND:  w_alu = w_a_ext & w_b_ext;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EXEC;
      EXEC:    if (r_cnt == 4'd0) w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: operands are captured on the accept edge so later input changes are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= IDW'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= w_gnt_op;
            r_a      <= w_a_arr[w_gnt_id];
            r_b      <= w_b_arr[w_gnt_id];
            r_id     <= w_gnt_id;
            r_rr_ptr <= w_gnt_id;
            r_cnt    <= w_lat_m1;
          end
        end
        EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_result    <= w_alu;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_op     = r_op;
  assign rsp_result = r_result;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler (NUM_REQ=4, WIDTH=8, MUL_LAT=3).
// Inputs change and outputs are sampled 1ns after the falling edge.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_op;
  logic [15:0] rsp_result;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_op_scheduler #(.NUM_REQ(4), .WIDTH(8), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_op(rsp_op), .rsp_result(rsp_result), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[i]    = v;
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = -1;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // req_ready must never be multi-hot.
  always @(negedge clk) begin
    if (mon_en) check_eq("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
  end

  logic [7:0] xa [4] = '{8'h5A, 8'h33, 8'hC3, 8'hFF};
  logic [7:0] xb [4] = '{8'h0F, 8'h55, 8'h3C, 8'h00};
  logic [7:0] xr [4] = '{8'h55, 8'h66, 8'hFF, 8'hFF};
  int exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    int gcount, rcount, last, gid, g3, r3, seen;

    rst = 1'b1; req_valid = 4'hF; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_result", 32'(rsp_result), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_op", 32'(rsp_op), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    mon_en = 1'b1;

    // ADD with carry; operands changed right after accept.
    set_req(0, 1'b1, 2'b00, 8'hFF, 8'h01);
    rsp_ready = 1'b1;
    #1;
    check_eq("add_grant", 32'(req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 2'b11, 8'h00, 8'h00);
    #1;
    check_eq("add_c1_busy", 32'(busy), 32'd1);
    check_eq("add_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("add_c1_req_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("add_rsp_result", 32'(rsp_result), 32'h0100);
    check_eq("add_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("add_rsp_op", 32'(rsp_op), 32'd0);
    tick();
    check_eq("add_done_valid", 32'(rsp_valid), 32'd0);
    check_eq("add_done_busy", 32'(busy), 32'd0);

    // MUL from requester 2, latency 3.
    set_req(2, 1'b1, 2'b10, 8'hFF, 8'hFF);
    #1;
    check_eq("mul_grant", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 2'b00, 8'h00, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      check_eq("mul_wait_valid", 32'(rsp_valid), 32'd0);
      check_eq("mul_wait_busy", 32'(busy), 32'd1);
      tick();
    end
    check_eq("mul_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("mul_rsp_result", 32'(rsp_result), 32'hFE01);
    check_eq("mul_rsp_id", 32'(rsp_id), 32'd2);
    check_eq("mul_rsp_op", 32'(rsp_op), 32'd2);
    check_eq("mul_rsp_busy", 32'(busy), 32'd1);
    tick();
    check_eq("mul_done_busy", 32'(busy), 32'd0);

    // Round-robin: all four hold XOR requests from reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b01, xa[i], xb[i]);
    rsp_ready = 1'b1;
    gcount = 0; rcount = 0; last = 0;
    for (int c = 0; c < 40 && gcount < 5; c++) begin
      #1;
      if (req_ready != 4'h0) begin
        gid = oh_idx(req_ready);
        check_eq("rr_grant", 32'(gid), 32'(exp_g[gcount]));
        if (gcount > 0) check_eq("rr_interval", 32'(c - last), 32'd3);
        last = c;
        gcount++;
      end
      if (rsp_valid && rcount < 4) begin
        check_eq("rr_rsp_id", 32'(rsp_id), 32'(exp_g[rcount]));
        check_eq("rr_rsp_result", 32'(rsp_result), {24'h0, xr[exp_g[rcount]]});
        rcount++;
      end
      tick();
    end
    check_eq("rr_grants_seen", 32'(gcount), 32'd5);
    check_eq("rr_rsps_seen", 32'(rcount), 32'd4);
    req_valid = '0;

    // Backpressure on an AND result while requester 1 waits.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b11, 8'hF0, 8'h3C);
    #1;
    check_eq("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1, 1'b1, 2'b00, 8'h03, 8'h04);
    #1;
    check_eq("bp_exec_ready", 32'(req_ready), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_hold_result", 32'(rsp_result), 32'h0030);
      check_eq("bp_hold_id", 32'(rsp_id), 32'd0);
      check_eq("bp_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_hs_ready", 32'(req_ready), 32'd0);
    check_eq("bp_hs_valid", 32'(rsp_valid), 32'd1);
    tick();
    check_eq("bp_after_valid", 32'(rsp_valid), 32'd0);
    check_eq("bp_grant1", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    check_eq("bp_r1_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp_r1_result", 32'(rsp_result), 32'h0007);
    check_eq("bp_r1_id", 32'(rsp_id), 32'd1);
    tick();

    // Reset while a MUL is in EXEC.
    set_req(2, 1'b1, 2'b10, 8'h10, 8'h10);
    #1;
    check_eq("rm_grant2", 32'(req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    rst = 1'b1;
    set_req(0, 1'b1, 2'b00, 8'h05, 8'h06);
    set_req(3, 1'b1, 2'b00, 8'h20, 8'h01);
    tick();
    check_eq("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rm_busy", 32'(busy), 32'd0);
    check_eq("rm_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rm_next_grant", 32'(req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(3, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    check_eq("rm_r0_valid", 32'(rsp_valid), 32'd1);
    check_eq("rm_r0_result", 32'(rsp_result), 32'h000B);
    check_eq("rm_r0_id", 32'(rsp_id), 32'd0);
    tick();

    // Requester 3 raises valid during EXEC of requester 1, then withdraws.
    set_req(1, 1'b1, 2'b10, 8'h12, 8'h34);
    #1;
    check_eq("dr_grant1", 32'(req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(3, 1'b1, 2'b01, 8'hAA, 8'h55);
    g3 = 0; r3 = 0; seen = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) set_req(3, 1'b0, 2'b00, 8'h00, 8'h00);
      #1;
      if (req_ready[3]) g3++;
      if (rsp_valid) begin
        if (rsp_id == 2'd3) r3++;
        else begin
          check_eq("dr_rsp_id", 32'(rsp_id), 32'd1);
          check_eq("dr_rsp_result", 32'(rsp_result), 32'h03A8);
          seen++;
        end
      end
      tick();
    end
    check_eq("dr_no_grant3", 32'(g3), 32'd0);
    check_eq("dr_no_rsp3", 32'(r3), 32'd0);
    check_eq("dr_rsp1_seen", 32'(seen), 32'd1);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one ALU (ADD, XOR, MUL, AND) between NUM_REQ requesters using round-robin arbitration.
- Sequences each granted operation through a fixed-latency execute phase and returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the requester agents and the shared ALU. It is the DUT controlled by the general sequencer/driver/monitor environment.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..8.
- WIDTH, 8, operand width in bits.
- MUL_LAT, 3, execute cycles for MUL; legal range 1..15. ADD/XOR/AND always take 1 cycle.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit set (one-hot).
- req_op  in  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]; 00 ADD, 01 XOR, 10 MUL, 11 AND.
- req_a  in  WIDTH*NUM_REQ  per-requester operand A.
- req_b  in  WIDTH*NUM_REQ  per-requester operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  max(1,$clog2(NUM_REQ))  index of the requester that owns the response.
- rsp_op  out  2  opcode of the response.
- rsp_result  out  2*WIDTH  operation result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), rsp_valid=0, rsp_id=0, rsp_op=0, rsp_result=0, busy=0, req_ready=0.
- IDLE:
  - req_ready is combinational, is asserted only in IDLE, and goes to the single winner: the first requester with req_valid=1 scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Accept edge (req_valid[g] & req_ready[g]): capture op, A, B and g; rr_ptr<=g; cnt<=lat-1, where lat=MUL_LAT for MUL and 1 otherwise; go to EXEC.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- EXEC:
  - cnt>0: decrement cnt.
  - cnt==0: register the result into rsp_result, assert rsp_valid, go to RESP.
  - req_ready=0 throughout EXEC.
- RESP:
  - rsp_valid held high; rsp_id, rsp_op and rsp_result held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the handshake cycle; arbitration resumes the following cycle.
- Latency: accept at edge T gives rsp_valid=1 from cycle T+1+lat.
  - ADD: rsp_valid in the 2nd cycle after accept.
  - MUL with MUL_LAT=3: rsp_valid in the 4th cycle after accept.
  - Minimum issue interval with rsp_ready tied high: lat+2 cycles.
- Arithmetic (all unsigned, zero-extended into 2*WIDTH bits):
  - ADD = A+B with the carry in bit WIDTH.
  - XOR = A^B.
  - AND = A&B.
  - MUL = full 2*WIDTH product.
- Boundary conditions:
  - A requester that drops req_valid before being granted loses nothing; the block keeps no pending state for it.
  - Operand or opcode changes after the accept edge have no effect on the operation in flight.
  - rsp_ready=1 while rsp_valid=0 is ignored.
  - rst asserted in any state aborts the operation in flight. No response is produced, and the block returns to the reset values on the next edge.
  - rst has priority over every simultaneous event.
  - NUM_REQ=1: rsp_id is 1 bit and always 0; arbitration is trivial.

Test Plan:
- Single ADD, WIDTH=8: req0 op=00, A=0xFF, B=0x01 → accept at edge T; rsp_valid rises at T+2 with rsp_result=0x0100, rsp_id=0, rsp_op=00.
- MUL latency: req2 op=10, A=0xFF, B=0xFF, MUL_LAT=3 → rsp_valid at T+4, rsp_result=0xFE01; busy=1 from T+1 until the handshake edge.
- Round-robin: all four requesters hold req_valid with XOR ops from reset, rsp_ready=1 → grant order 0,1,2,3,0; each issue is 3 cycles apart; req_ready is never multi-hot.
- Backpressure: AND, A=0xF0, B=0x3C, rsp_ready=0 for 5 cycles → rsp_valid stays high with rsp_result=0x0030 stable; no req_ready while a pending req1 waits; req1 is granted the cycle after the rsp_ready handshake.
- Reset mid-op: MUL accepted, rst=1 at EXEC cycle 2 → next cycle rsp_valid=0, busy=0, state IDLE; the next grant goes to req0.
- Drop before grant: req3 valid for 2 cycles during EXEC of req1, then deasserted → req3 is never granted and no response carries rsp_id=3.
